bcd_display_scanner: RTL and testbench

Time-multiplexed 7-segment driver for the three BCD digits (d0 units, d1 tens, d2 hundreds) produced by the counter selection path. It takes a coherent snapshot of the digits once per display frame and scans them one at a time onto a shared active-low segment bus with active-low digit enables. Each digit slot starts with a ghost-suppression blanking gap. It sits between the counter manager outputs and the board's common-anode display pins.

---
 rtl/bcd_display_scanner_pkg.sv | 37 +++
 rtl/bcd_display_scanner_bcd_to_seg7.sv | 26 ++
 rtl/bcd_display_scanner.sv | 99 +++++++++
 tb/tb_bcd_display_scanner.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and types for the BCD 7-segment display scanner:
// active-low segment patterns {g,f,e,d,c,b,a}, digit index type and digit enables.
package bcd_display_scanner_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef logic [1:0] digit_idx_t;
  localparam digit_idx_t DIGIT_LAST = 2'd2;

  localparam logic [2:0] AN_D0  = 3'b110;
  localparam logic [2:0] AN_D1  = 3'b101;
  localparam logic [2:0] AN_D2  = 3'b011;
  localparam logic [2:0] AN_OFF = 3'b111;

  // Slot phase: BLANK is the ghost-suppression gap, SHOW drives one digit.
  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

  function automatic logic [2:0] an_for(input digit_idx_t i);
    case (i)
      2'd0:    an_for = AN_D0;
      2'd1:    an_for = AN_D1;
      default: an_for = AN_D2;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit common-anode display scanner with per-frame snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 2 and 1.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt, cnt_d;
  digit_idx_t    idx, idx_d;
  scan_state_t   state, state_d;
  logic [3:0]    s0, s1, s2;
  logic          capture;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          lz_blank;
  logic [6:0]    seg_d;
  logic [2:0]    an_d;

  assign cur_digit = (idx == 2'd0) ? s0 : (idx == 2'd1) ? s1 : s2;

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = ((idx == 2'd2) && (s2 == 4'd0)) ||
                    ((idx == 2'd1) && (s1 == 4'd0) && (s2 == 4'd0));
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs are computed from the pre-edge cnt/idx and registered below.
  always_comb begin
    cnt_d   = cnt;
    idx_d   = idx;
    state_d = state;
    capture = 1'b0;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    if (en) begin
      capture = (cnt == '0) && (idx == 2'd0);
      if (state == ST_SHOW) begin
        an_d  = an_for(idx);
        seg_d = lz_blank ? SEG_OFF : cur_seg;
      end
      if (cnt == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx == DIGIT_LAST) ? 2'd0 : idx + 2'd1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
      state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      state      <= ST_BLANK;
      s0         <= 4'd0;
      s1         <= 4'd0;
      s2         <= 4'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      idx        <= idx_d;
      state      <= state_d;
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= capture;
      if (capture) begin
        s0 <= d0;
        s1 <= d1;
        s2 <= d2;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (SCAN_DIV=8, BLANK_CYCLES=2) with an expected-output queue.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] d0, d1, d2;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  bcd_display_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Scoreboard entries are {frame_done, an, seg}.
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int pos      = 0;
  logic [3:0] m0 = 4'd0, m1 = 4'd0, m2 = 4'd0;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: ref_seg = 7'b1000000;
      4'd1: ref_seg = 7'b1111001;
      4'd2: ref_seg = 7'b0100100;
      4'd3: ref_seg = 7'b0110000;
      4'd4: ref_seg = 7'b0011001;
      4'd5: ref_seg = 7'b0010010;
      4'd6: ref_seg = 7'b0000010;
      4'd7: ref_seg = 7'b1111000;
      4'd8: ref_seg = 7'b0000000;
      4'd9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input int slot);
    logic [6:0] r;
    r = (slot == 0) ? ref_seg(m0) : (slot == 1) ? ref_seg(m1) : ref_seg(m2);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2 && m2 == 4'd0) r = 7'b1111111;
    if (slot == 1 && m1 == 4'd0 && m2 == 4'd0) r = 7'b1111111;
`endif
    return r;
  endfunction

  function automatic logic [2:0] ref_an(input int slot);
    return (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Expected output for one edge: frame position pos (0..23) advances only while en=1.
  task automatic tick();
    logic [10:0] e;
    logic [10:0] got;
    int slot, p;
    if (en) begin
      if (pos == 0) begin
        m0 = d0; m1 = d1; m2 = d2;
      end
      slot = pos / 8;
      p    = pos % 8;
      if (p < 2) e = {(pos == 0), 3'b111, 7'b1111111};
      else       e = {1'b0, ref_an(slot), ref_digit(slot)};
      pos = (pos + 1) % 24;
    end else begin
      e = {1'b0, 3'b111, 7'b1111111};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ncyc++;
    got = {frame_done, an, seg};
    e = exp_q.pop_front();
    check($sformatf("cyc%0d", ncyc), got, e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d0 = 4'd0; d1 = 4'd0; d2 = 4'd0;
    #12;
    check("reset", {frame_done, an, seg}, {1'b0, 3'b111, 7'b1111111});

    // 1/2/3 display, then d0 changes mid-frame and must wait for the next capture.
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    en = 1'b1;
    rst_n = 1'b1;
    ticks(10);
    d0 = 4'd7;
    ticks(14);
    ticks(24);

    // Invalid BCD shows a dash.
    d0 = 4'd12;
    ticks(24);
    ticks(24);

    // Leading zeros: 0/0/5.
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd5;
    ticks(48);

    // Enable drop mid-slot, then resume from the held position.
    d2 = 4'd4; d1 = 4'd0; d0 = 4'd9;
    ticks(13);
    en = 1'b0;
    ticks(5);
    en = 1'b1;
    ticks(30);

    // Async reset during a SHOW cycle.
    check("pre_reset_show", {1'b0, an}, {1'b0, 3'b011});
    rst_n = 1'b0;
    #2;
    check("async_reset", {frame_done, an, seg}, {1'b0, 3'b111, 7'b1111111});
    @(posedge clk);
    #1;
    check("reset_held", {frame_done, an, seg}, {1'b0, 3'b111, 7'b1111111});
    d2 = 4'd9; d1 = 4'd8; d0 = 4'd6;
    pos = 0;
    m0 = 4'd0; m1 = 4'd0; m2 = 4'd0;
    #2;
    rst_n = 1'b1;
    ticks(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
